load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the 8-bit data memory (256 x 8, combinational read, write on clk rising edge).
- Accepts byte and halfword load/store requests from the core over a valid/ready handshake.
- Splits each halfword into two little-endian byte accesses on the memory port.
- Returns load data, sign- or zero-extended to 16 bits, with a one-cycle response pulse.

Parameters:
- ADDR_W, 8, address width of the memory port and the request address; byte addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_size  input  1  0 = byte, 1 = halfword
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  ADDR_W  byte address
- req_wdata  input  16  store data; a byte store uses [7:0]
- resp_valid  output  1  one-cycle completion pulse for loads and stores
- resp_rdata  output  16  load result, valid while resp_valid=1; 0 for stores
- resp_err  output  1  error flag qualified by resp_valid (see Optional Feature)
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wd  output  8  memory write data
- mem_rd  input  8  memory combinational read data

Behaviour:
- Reset (rst=0, asynchronous) puts the FSM in IDLE and forces these outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0. Internal request registers are cleared.
- Reset asserted mid-operation aborts the transaction immediately. mem_we drops asynchronously, no response is issued, and a half-written halfword is not rolled back.
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On a rising edge with req_valid=1, latch we/size/signed/addr/wdata and go to ACC0.
  - Request fields are sampled only at this edge; later changes are ignored.
- ACC0:
  - mem_addr = addr. For a store, mem_we=1 and mem_wd = wdata[7:0].
  - For a load, mem_we=0 and mem_rd is captured into the low byte at the end of the cycle.
  - Next state is ACC1 if size=1, otherwise RESP.
- ACC1:
  - mem_addr = addr+1, truncated to ADDR_W, so 0xFF+1 = 0x00.
  - For a store, mem_we=1 and mem_wd = wdata[15:8]. For a load, mem_rd is captured into the high byte.
  - Next state is RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; there is no backpressure. mem_we=0.
  - Next state is IDLE, so req_ready is high again on the following cycle.
- Load result:
  - Byte, signed: {8{b0[7]}, b0}. Byte, unsigned: {8'h00, b0}.
  - Halfword: {b1, b0}; req_signed is ignored.
- Latency from the accept edge to resp_valid: byte = 2 cycles, halfword = 3 cycles.
- Throughput: one request per 3 cycles (byte) or 4 cycles (halfword).
- mem_* outputs are driven only from registered state (no combinational path from req_* inputs). Outside ACC0/ACC1, mem_we=0 and mem_addr/mem_wd hold their last values.
- resp_rdata holds its value until the next load's RESP. Stores drive resp_rdata=0 during RESP.

Optional Feature:
- Macro LSU_MISALIGN_CHECK_EN.
- Defined: a halfword request with addr[0]=1 is accepted normally but skips ACC0/ACC1. The unit goes straight to RESP with resp_err=1 and resp_rdata=0, and issues no memory access (mem_we stays 0). resp_err is 0 for all other requests.
- Undefined: misaligned halfwords execute normally with address wrap, and resp_err is tied to 0.

Test Plan:
- Reset check: hold rst=0, then release it. Immediately after release: req_ready=1, resp_valid=0, mem_we=0, mem_addr=0x00. A request presented in the first cycle is accepted.
- Halfword store, then signed halfword load: store addr=0x10, wdata=0xBEEF. Expect mem_we pulses at 0x10 with 0xEF, then at 0x11 with 0xBE. Then load addr=0x10, resp_rdata=0xBEEF with resp_valid exactly 3 cycles after accept.
- Byte sign extension: store byte 0x80 at 0x20. A signed byte load returns 0xFF80; an unsigned byte load returns 0x0080; each response arrives 2 cycles after accept.
- Wrap-around: halfword store 0x1234 at 0xFF. Expect 0x34 written to 0xFF and 0x12 written to 0x00. With LSU_MISALIGN_CHECK_EN defined, expect instead resp_err=1, no mem_we pulse, and resp_rdata=0.
- Back-to-back and held inputs: keep req_valid=1 continuously with two byte loads. Expect req_ready=0 during ACC0/RESP, the second request accepted only in IDLE, and changes to req_addr during ACC0 ignored.
- Reset mid-store: assert rst=0 during ACC0 of a halfword store. Expect mem_we=0 immediately, no resp_valid ever, and only the byte at addr (if its edge completed) modified.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Core request/response and byte-wide data memory bundle for the LSU.
interface load_store_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              resp_valid;
    logic [15:0]       resp_rdata;
    logic              resp_err;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wd;
    logic [7:0]        mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_signed,
        input  req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_we, mem_addr, mem_wd
    );

    modport master (
        output req_valid, req_we, req_size, req_signed,
        output req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_we, mem_addr, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword load-store unit over an 8-bit memory port.
// Optional misaligned-halfword trap: LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

    state_e            state_q, state_d;
    logic              we_q, size_q, sgn_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [7:0]        b0_q, b1_q;
    logic [15:0]       hold_q;
    logic [ADDR_W-1:0] maddr_q;
    logic [7:0]        mwd_q;
    logic              accept;
    logic              misal;
    logic [15:0]       ld_data;

    assign accept = (state_q == IDLE) && bus.req_valid;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misal = bus.req_size & bus.req_addr[0];
`else
    assign misal = 1'b0;
`endif

    always_comb begin
        ld_data = {8'h00, b0_q};
        if (size_q)
            ld_data = {b1_q, b0_q};
        else if (sgn_q)
            ld_data = {{8{b0_q[7]}}, b0_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.req_valid) state_d = misal ? RESP : ACC0;
            ACC0: state_d = size_q ? ACC1 : RESP;
            ACC1: state_d = RESP;
            RESP: state_d = IDLE;
        endcase
    end

    // mem_addr/mem_wd hold their last driven value outside the access states
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = hold_q;
        bus.resp_err   = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = maddr_q;
        bus.mem_wd     = mwd_q;
        unique case (state_q)
            IDLE: bus.req_ready = 1'b1;
            ACC0: begin
                bus.mem_addr = addr_q;
                if (we_q) begin
                    bus.mem_we = 1'b1;
                    bus.mem_wd = wdata_q[7:0];
                end
            end
            ACC1: begin
                bus.mem_addr = addr_q + 1'b1;
                if (we_q) begin
                    bus.mem_we = 1'b1;
                    bus.mem_wd = wdata_q[15:8];
                end
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (we_q || err_q) ? 16'h0000 : ld_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            sgn_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            hold_q  <= '0;
            maddr_q <= '0;
            mwd_q   <= '0;
        end else begin
            maddr_q <= bus.mem_addr;
            mwd_q   <= bus.mem_wd;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                sgn_q   <= bus.req_signed;
                err_q   <= misal;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state_q == ACC0 && !we_q) b0_q <= bus.mem_rd;
            if (state_q == ACC1 && !we_q) b1_q <= bus.mem_rd;
            if (state_q == RESP && !we_q && !err_q) hold_q <= ld_data;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a 256x8 memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if #(.ADDR_W(8)) bus ();

    load_store_unit #(.ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    assign bus.mem_rd = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wd;

    logic [7:0] wa [$];
    logic [7:0] wd [$];
    always @(negedge clk) if (bus.mem_we) begin
        wa.push_back(bus.mem_addr);
        wd.push_back(bus.mem_wd);
    end

    typedef struct {
        logic        we;
        logic        size;
        logic        sgn;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rd;
        int          lat;
        logic        err;
        int          nw;
        logic [7:0]  a0, d0, a1, d1;
    } vec_t;

    vec_t v [12];

    function automatic vec_t mk(logic we, logic size, logic sgn,
                                logic [7:0] a, logic [15:0] w,
                                logic [15:0] rd, int lat, logic err,
                                int nw, logic [7:0] a0, logic [7:0] d0,
                                logic [7:0] a1, logic [7:0] d1);
        vec_t t;
        t.we = we; t.size = size; t.sgn = sgn; t.addr = a; t.wdata = w;
        t.rd = rd; t.lat = lat; t.err = err; t.nw = nw;
        t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
        return t;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the unit idle; returns at a negedge, idle again.
    task automatic run_req(vec_t t, int idx);
        int lat;
        logic [7:0] ea [2];
        logic [7:0] ed [2];
        ea[0] = t.a0; ea[1] = t.a1; ed[0] = t.d0; ed[1] = t.d1;
        wa.delete();
        wd.delete();
        chk($sformatf("v%0d_ready", idx), bus.req_ready, 1'b1);
        bus.req_we     = t.we;
        bus.req_size   = t.size;
        bus.req_signed = t.sgn;
        bus.req_addr   = t.addr;
        bus.req_wdata  = t.wdata;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 8'h5A;
        bus.req_wdata = 16'hDEAD;
        lat = 1;
        while (!bus.resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("v%0d_lat", idx), lat, t.lat);
        chk($sformatf("v%0d_rdata", idx), bus.resp_rdata, t.rd);
        chk($sformatf("v%0d_err", idx), bus.resp_err, t.err);
        chk($sformatf("v%0d_nwrites", idx), wa.size(), t.nw);
        for (int k = 0; k < wa.size() && k < t.nw && k < 2; k++) begin
            chk($sformatf("v%0d_waddr%0d", idx, k), wa[k], ea[k]);
            chk($sformatf("v%0d_wdata%0d", idx, k), wd[k], ed[k]);
        end
        @(negedge clk);
        chk($sformatf("v%0d_pulse", idx), bus.resp_valid, 1'b0);
        chk($sformatf("v%0d_ready_after", idx), bus.req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 1'b0;
        bus.req_signed = 1'b0; bus.req_addr = 8'h00; bus.req_wdata = 16'h0;

        v[0]  = mk(1, 1, 0, 8'h10, 16'hBEEF, 16'h0000, 3, 0, 2,
                   8'h10, 8'hEF, 8'h11, 8'hBE);
        v[1]  = mk(0, 1, 1, 8'h10, 16'h0000, 16'hBEEF, 3, 0, 0, 0, 0, 0, 0);
        v[2]  = mk(1, 0, 0, 8'h20, 16'h0080, 16'h0000, 2, 0, 1,
                   8'h20, 8'h80, 0, 0);
        v[3]  = mk(0, 0, 1, 8'h20, 16'h0000, 16'hFF80, 2, 0, 0, 0, 0, 0, 0);
        v[4]  = mk(0, 0, 0, 8'h20, 16'h0000, 16'h0080, 2, 0, 0, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        v[5]  = mk(1, 1, 0, 8'hFF, 16'h1234, 16'h0000, 1, 1, 0, 0, 0, 0, 0);
        v[6]  = mk(0, 1, 0, 8'hFF, 16'h0000, 16'h0000, 1, 1, 0, 0, 0, 0, 0);
        v[7]  = mk(0, 1, 0, 8'h00, 16'h0000, 16'h0000, 3, 0, 0, 0, 0, 0, 0);
`else
        v[5]  = mk(1, 1, 0, 8'hFF, 16'h1234, 16'h0000, 3, 0, 2,
                   8'hFF, 8'h34, 8'h00, 8'h12);
        v[6]  = mk(0, 1, 0, 8'hFF, 16'h0000, 16'h1234, 3, 0, 0, 0, 0, 0, 0);
        v[7]  = mk(0, 1, 0, 8'h00, 16'h0000, 16'h0012, 3, 0, 0, 0, 0, 0, 0);
`endif
        v[8]  = mk(1, 0, 1, 8'h30, 16'h55AA, 16'h0000, 2, 0, 1,
                   8'h30, 8'hAA, 0, 0);
        v[9]  = mk(0, 1, 1, 8'h30, 16'h0000, 16'h00AA, 3, 0, 0, 0, 0, 0, 0);
        v[10] = mk(0, 0, 1, 8'h30, 16'h0000, 16'hFFAA, 2, 0, 0, 0, 0, 0, 0);
        v[11] = mk(0, 0, 0, 8'h11, 16'h0000, 16'h00BE, 2, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_valid", bus.resp_valid, 1'b0);
        chk("rst_rdata", bus.resp_rdata, 16'h0000);
        chk("rst_err", bus.resp_err, 1'b0);
        chk("rst_we", bus.mem_we, 1'b0);
        chk("rst_addr", bus.mem_addr, 8'h00);
        chk("rst_wd", bus.mem_wd, 8'h00);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) run_req(v[i], i);

        // Held req_valid: second request taken only once back in IDLE
        bus.req_we = 1'b0; bus.req_size = 1'b0; bus.req_signed = 1'b0;
        bus.req_addr = 8'h20; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_acc0_ready", bus.req_ready, 1'b0);
        bus.req_addr = 8'h30;
        @(negedge clk);
        chk("b2b_resp1_ready", bus.req_ready, 1'b0);
        chk("b2b_resp1_valid", bus.resp_valid, 1'b1);
        chk("b2b_resp1_rdata", bus.resp_rdata, 16'h0080);
        @(negedge clk);
        chk("b2b_idle_ready", bus.req_ready, 1'b1);
        chk("b2b_idle_valid", bus.resp_valid, 1'b0);
        @(negedge clk);
        chk("b2b_acc0b_ready", bus.req_ready, 1'b0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_resp2_valid", bus.resp_valid, 1'b1);
        chk("b2b_resp2_rdata", bus.resp_rdata, 16'h00AA);
        @(negedge clk);

        // Reset during ACC0 of a halfword store
        bus.req_we = 1'b1; bus.req_size = 1'b1; bus.req_addr = 8'h40;
        bus.req_wdata = 16'hC3A5; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("mid_we_acc0", bus.mem_we, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_we_async", bus.mem_we, 1'b0);
        chk("mid_ready", bus.req_ready, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mid_noresp%0d", i), bus.resp_valid, 1'b0);
        end
        chk("mid_mem40", mem[8'h40], 8'h00);
        chk("mid_mem41", mem[8'h41], 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
